// File: rtl/montgomery_reduce_ws.sv
// Word-serial Montgomery reduction: streams T (2S blocks) in and T*R^-1 mod N (S blocks) out.
// Row-by-row in-place REDC over a 2S-block scratch with a one-bit overflow above the top block.
module montgomery_reduce_ws #(
  parameter int REGISTER_SIZE  = 32,
  parameter int NUM_BLOCKS_OUT = 128,
  parameter bit SKIP_FINAL_SUB = 1'b0
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     n_valid_in,
  input  logic [REGISTER_SIZE-1:0] n_block_in,
  input  logic [REGISTER_SIZE-1:0] n0_inv_in,
  output logic                     n_loaded_out,
  input  logic                     valid_in,
  input  logic [REGISTER_SIZE-1:0] T_block_in,
  output logic                     ready_out,
  output logic                     valid_out,
  output logic [REGISTER_SIZE-1:0] data_block_out,
  output logic                     final_out,
  input  logic                     ready_in,
  output logic                     busy_out
);
  localparam int W  = REGISTER_SIZE;
  localparam int S  = NUM_BLOCKS_OUT;
  localparam int NW = $clog2(S);
  localparam int IW = $clog2(2 * S);
  localparam logic [NW-1:0] LAST_J  = NW'(S - 1);
  localparam logic [IW-1:0] LAST_T  = IW'(2 * S - 1);
  localparam logic [IW-1:0] T_FIRST = '0;

  typedef enum logic [2:0] {IDLE, LOAD_T, MROW, ACC, CARRY, CMP, OUT} state_e;
  state_e state_q, state_d;

  logic [W-1:0]  n_q [S];
  logic [W-1:0]  t_q [2*S];
  logic [W-1:0]  n0_inv_q, m_q, c_q;
  logic          ov_q, sub_q, brw_q;
  logic [NW-1:0] nk_q, i_q, j_q;
  logic [IW-1:0] tk_q;
  logic          n_loaded_q;

  logic          t_acc, n_acc, o_acc;
  logic [IW-1:0] idx_acc, idx_top, idx_hi;
  logic [W-1:0]  mul_a, mul_b;
  logic [2*W-1:0] prod, acc_sum;
  logic [W:0]    car_sum, diff;

  function automatic logic [W:0] sub_brw(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bin);
    return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  endfunction

  function automatic logic [W:0] add_cy(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  assign t_acc = valid_in && ready_out;
  assign n_acc = (state_q == IDLE) && n_valid_in && !t_acc;
  assign o_acc = (state_q == OUT) && ready_in;

  assign idx_acc = IW'(i_q) + IW'(j_q);
  assign idx_top = IW'(i_q) + IW'(S);
  assign idx_hi  = IW'(S) + IW'(j_q);

  // One shared W x W multiplier: m in MROW, m*N[j] in ACC
  assign mul_a   = (state_q == MROW) ? t_q[IW'(i_q)] : m_q;
  assign mul_b   = (state_q == MROW) ? n0_inv_q : n_q[j_q];
  assign prod    = (2*W)'(mul_a) * (2*W)'(mul_b);
  assign acc_sum = (2*W)'(t_q[idx_acc]) + prod + (2*W)'(c_q);
  assign car_sum = add_cy(t_q[idx_top], c_q, ov_q);
  assign diff    = sub_brw(t_q[idx_hi], n_q[j_q], brw_q);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (t_acc) state_d = LOAD_T;
      LOAD_T:  if (t_acc && tk_q == LAST_T) state_d = MROW;
      MROW:    state_d = ACC;
      ACC:     if (j_q == LAST_J) state_d = CARRY;
      CARRY:   state_d = (i_q == LAST_J) ? CMP : MROW;
      CMP:     if (j_q == LAST_J) state_d = OUT;
      OUT:     if (o_acc && j_q == LAST_J) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_out      = (state_q == IDLE) ? n_loaded_q : (state_q == LOAD_T);
    valid_out      = (state_q == OUT);
    final_out      = (state_q == OUT) && (j_q == LAST_J);
    busy_out       = (state_q != IDLE);
    n_loaded_out   = n_loaded_q;
    data_block_out = '0;
    if (state_q == OUT) data_block_out = sub_q ? diff[W-1:0] : t_q[idx_hi];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      nk_q       <= '0;
      n_loaded_q <= 1'b0;
      tk_q       <= '0;
      i_q        <= '0;
      j_q        <= '0;
    end else begin
      if (n_acc) begin
        nk_q       <= (nk_q == LAST_J) ? '0 : nk_q + 1'b1;
        n_loaded_q <= (nk_q == LAST_J);
      end
      case (state_q)
        IDLE: begin
          i_q <= '0;
          j_q <= '0;
          if (t_acc) tk_q <= IW'(1);
        end
        LOAD_T:   if (t_acc) tk_q <= tk_q + 1'b1;
        MROW:     j_q <= '0;
        ACC, CMP: j_q <= (j_q == LAST_J) ? '0 : j_q + 1'b1;
        CARRY: begin
          j_q <= '0;
          i_q <= (i_q == LAST_J) ? '0 : i_q + 1'b1;
        end
        OUT:      if (o_acc) j_q <= (j_q == LAST_J) ? '0 : j_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Datapath storage carries no reset; the FSM decides when each word is meaningful
  always_ff @(posedge clk_in) begin
    case (state_q)
      IDLE: begin
        if (n_acc) n_q[nk_q] <= n_block_in;
        if (t_acc) begin
          t_q[T_FIRST] <= T_block_in;
          n0_inv_q     <= n0_inv_in;
          ov_q         <= 1'b0;
        end
      end
      LOAD_T: if (t_acc) t_q[tk_q] <= T_block_in;
      MROW: begin
        m_q <= prod[W-1:0];
        c_q <= '0;
      end
      ACC: begin
        t_q[idx_acc] <= acc_sum[W-1:0];
        c_q          <= acc_sum[2*W-1:W];
      end
      CARRY: begin
        t_q[idx_top] <= car_sum[W-1:0];
        ov_q         <= car_sum[W];
        brw_q        <= 1'b0;
      end
      CMP: begin
        brw_q <= diff[W];
        if (j_q == LAST_J) begin
          sub_q <= !SKIP_FINAL_SUB && (ov_q || !diff[W]);
          brw_q <= 1'b0;
        end
      end
      OUT: if (o_acc) brw_q <= diff[W];
      default: ;
    endcase
  end

endmodule

// File: tb/tb_montgomery_reduce_ws.sv
// Bench for montgomery_reduce_ws at W=8, S=2: directed vectors, corner sequences, and random
// operations checked against a textbook full-width REDC model.
module tb_montgomery_reduce_ws;
  localparam int W = 8;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       n_valid_in = 1'b0;
  logic [7:0] n_block_in = '0;
  logic [7:0] n0_inv_in = '0;
  logic       valid_in = 1'b0;
  logic [7:0] T_block_in = '0;
  logic       ready_in = 1'b0;

  logic       n_loaded_out, ready_out, valid_out, final_out, busy_out;
  logic [7:0] data_block_out;
  logic       lz_n_loaded, lz_ready, lz_valid, lz_final, lz_busy;
  logic [7:0] lz_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  montgomery_reduce_ws #(.REGISTER_SIZE(W), .NUM_BLOCKS_OUT(S), .SKIP_FINAL_SUB(1'b0)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .n_valid_in(n_valid_in), .n_block_in(n_block_in),
    .n0_inv_in(n0_inv_in), .n_loaded_out(n_loaded_out), .valid_in(valid_in),
    .T_block_in(T_block_in), .ready_out(ready_out), .valid_out(valid_out),
    .data_block_out(data_block_out), .final_out(final_out), .ready_in(ready_in),
    .busy_out(busy_out)
  );

  montgomery_reduce_ws #(.REGISTER_SIZE(W), .NUM_BLOCKS_OUT(S), .SKIP_FINAL_SUB(1'b1)) dut_lz (
    .clk_in(clk), .rst_n_in(rst_n), .n_valid_in(n_valid_in), .n_block_in(n_block_in),
    .n0_inv_in(n0_inv_in), .n_loaded_out(lz_n_loaded), .valid_in(valid_in),
    .T_block_in(T_block_in), .ready_out(lz_ready), .valid_out(lz_valid),
    .data_block_out(lz_data), .final_out(lz_final), .ready_in(ready_in),
    .busy_out(lz_busy)
  );

  typedef struct {
    logic [15:0] n;
    logic [31:0] t;
    logic [15:0] exp;
    logic [15:0] exp_lz;
    bit          stall;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Textbook REDC on whole integers: u = (T + M*N)/R with T + M*N == 0 mod R
  function automatic longint inv_neg(input longint n);
    longint inv = n;
    for (int k = 0; k < 5; k++) inv = (inv * (2 - n * inv)) & 64'hFFFF;
    return (64'h10000 - inv) & 64'hFFFF;
  endfunction

  function automatic longint redc(input longint t, input longint n, input bit lazy);
    longint m, u;
    m = ((t & 64'hFFFF) * inv_neg(n)) & 64'hFFFF;
    u = (t + m * n) >> 16;
    if (!lazy && u >= n) u = u - n;
    return u;
  endfunction

  task automatic load_n(input logic [15:0] n);
    for (int k = 0; k < S; k++) begin
      @(negedge clk);
      n_valid_in = 1'b1;
      n_block_in = n[8*k +: 8];
    end
    @(negedge clk);
    n_valid_in = 1'b0;
  endtask

  task automatic send_t(input logic [31:0] t, input logic [7:0] ninv, input bit npulse);
    for (int k = 0; k < 2*S; k++) begin
      int w = 0;
      @(negedge clk);
      valid_in   = 1'b1;
      T_block_in = t[8*k +: 8];
      n0_inv_in  = ninv;
      if (npulse && k > 0) begin
        n_valid_in = 1'b1;
        n_block_in = 8'h33;
      end
      while (!ready_out && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) chk("t_ready_timeout", w, 0);
    end
    @(negedge clk);
    valid_in   = 1'b0;
    n_valid_in = 1'b0;
  endtask

  task automatic collect(input bit stall, input bit npulse,
                         output logic [15:0] res, output logic [15:0] res_lz);
    int got = 0;
    int cyc = 0;
    logic [7:0] held = '0;
    bit pend = 1'b0;
    bit rdy = 1'b1;
    res = '0;
    res_lz = '0;
    while (got < S && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (npulse) begin
        n_valid_in = 1'b1;
        n_block_in = 8'h33;
      end
      if (valid_out) begin
        if (pend) chk("hold_stable", data_block_out, held);
        rdy = stall ? ~rdy : 1'b1;
        ready_in = rdy;
        if (rdy) begin
          res[8*got +: 8]    = data_block_out;
          res_lz[8*got +: 8] = lz_data;
          chk("final_flag", final_out, (got == S - 1));
          chk("lazy_valid", lz_valid, 1);
          got++;
          pend = 1'b0;
        end else begin
          held = data_block_out;
          pend = 1'b1;
        end
      end
    end
    if (got < S) chk("out_timeout", got, S);
    @(negedge clk);
    ready_in   = 1'b0;
    n_valid_in = 1'b0;
    chk("busy_after_final", busy_out, 0);
    chk("valid_after_final", valid_out, 0);
  endtask

  task automatic run_op(input logic [31:0] t, input logic [7:0] ninv, input bit stall,
                        input bit npulse, output logic [15:0] res,
                        output logic [15:0] res_lz, output int lat);
    send_t(t, ninv, npulse);
    lat = 1;
    while (!valid_out && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    collect(stall, npulse, res, res_lz);
  endtask

  task automatic chk_lat(input int lat);
    checks++;
    if (lat < S*(S+2) || lat > S*(S+2) + S + 1) begin
      errors++;
      $display("FAIL latency: got %0d cycles, allowed %0d..%0d", lat, S*(S+2), S*(S+2)+S+1);
    end
  endtask

  initial begin
    vec_t        vecs[4];
    logic [15:0] res, res_lz;
    int          lat;
    int          seen;

    vecs[0] = '{n: 16'h00FB, t: 32'h0005_0000, exp: 16'h0005, exp_lz: 16'h0005, stall: 1'b0};
    vecs[1] = '{n: 16'h00FB, t: 32'h00FA_FFFF, exp: 16'h000A, exp_lz: 16'h0105, stall: 1'b0};
    vecs[2] = '{n: 16'h00FB, t: 32'h00FA_0000, exp: 16'h00FA, exp_lz: 16'h00FA, stall: 1'b0};
    vecs[3] = '{n: 16'h00FB, t: 32'h00FA_FFFF, exp: 16'h000A, exp_lz: 16'h0105, stall: 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_valid", valid_out, 0);
    chk("rst_ready", ready_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_n_loaded", n_loaded_out, 0);
    chk("rst_data", data_block_out, 0);
    rst_n = 1'b1;

    load_n(16'h00FB);
    chk("n_loaded", n_loaded_out, 1);
    chk("ready_idle", ready_out, 1);

    for (int v = 0; v < 4; v++) begin
      run_op(vecs[v].t, 8'hCD, vecs[v].stall, 1'b0, res, res_lz, lat);
      chk($sformatf("vec%0d_result", v), res, vecs[v].exp);
      chk($sformatf("vec%0d_lazy", v), res_lz, vecs[v].exp_lz);
      chk_lat(lat);
    end

    // Reset pulse while the first row is accumulating
    send_t(32'h0005_0000, 8'hCD, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", valid_out, 0);
    chk("abort_busy", busy_out, 0);
    chk("abort_ready", ready_out, 0);
    chk("abort_final", final_out, 0);
    chk("abort_data", data_block_out, 0);
    chk("abort_n_loaded", n_loaded_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (valid_out || busy_out) seen++;
    end
    chk("no_output_after_abort", seen, 0);
    load_n(16'h00FB);
    run_op(32'h0005_0000, 8'hCD, 1'b0, 1'b0, res, res_lz, lat);
    chk("after_abort_result", res, 16'h0005);

    // N-load attempts while busy must not disturb the stored modulus
    run_op(32'h0005_0000, 8'hCD, 1'b0, 1'b1, res, res_lz, lat);
    chk("npulse_result", res, 16'h0005);
    chk("npulse_n_loaded", n_loaded_out, 1);
    run_op(32'h0005_0000, 8'hCD, 1'b0, 1'b0, res, res_lz, lat);
    chk("npulse_followup", res, 16'h0005);

    for (int r = 0; r < 20; r++) begin
      longint n, t;
      n = longint'($urandom_range(1, 16383)) * 2 + 1;
      t = longint'({32'b0, $urandom()}) % (n * 65536);
      load_n(n[15:0]);
      run_op(t[31:0], inv_neg(n) & 64'hFF, r[0], 1'b0, res, res_lz, lat);
      chk($sformatf("rand%0d_result n=%0h t=%0h", r, n, t), res, redc(t, n, 1'b0));
      chk($sformatf("rand%0d_lazy n=%0h t=%0h", r, n, t), res_lz, redc(t, n, 1'b1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
